// File: rtl/sensor_responder.sv
// sensor_responder: sensor-side UART endpoint that decodes {addr, cmd} requests
// and answers matching requests with {addr, payload, checksum}.
module sensor_responder #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SENSOR_ADDR  = 8'h01,
    parameter int         BYTE_TIMEOUT = 5000,
    parameter int         RESP_GAP     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic [7:0] sensor_data,
    input  logic       sensor_valid,
    output logic       tx,
    output logic       busy,
    output logic       frame_err
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int RW   = $clog2(CLKS_PER_BIT);
    localparam int M1   = BYTE_TIMEOUT > RESP_GAP ? BYTE_TIMEOUT : RESP_GAP;
    localparam int MAXC = M1 > CLKS_PER_BIT ? M1 : CLKS_PER_BIT;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_phase_t;
    typedef enum logic [2:0] {IDLE, RX_ADDR, RX_CMD, CHECK, GAP, TX_ADDR, TX_DATA, TX_SUM} state_t;

    logic rx_s1_q, rx_s2_q, rx_prev_q;
    rx_phase_t rph_q, rph_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [2:0] rbit_q, rbit_d;
    logic [7:0] shift_q, shift_d;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] tbit_q, tbit_d;
    logic match_q, match_d;
    logic [7:0] payload_q, payload_d;
    logic tx_q, tx_d, err_q, err_d;
    logic rx_en, start_ok, byte_done, stop_err;
    logic [7:0] tbyte;
    logic [9:0] frame;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rph_q     <= R_IDLE;
            rcnt_q    <= '0;
            rbit_q    <= '0;
            shift_q   <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            tbit_q    <= '0;
            match_q   <= 1'b0;
            payload_q <= '0;
            tx_q      <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rph_q     <= rph_d;
            rcnt_q    <= rcnt_d;
            rbit_q    <= rbit_d;
            shift_q   <= shift_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tbit_q    <= tbit_d;
            match_q   <= match_d;
            payload_q <= payload_d;
            tx_q      <= tx_d;
            err_q     <= err_d;
        end
    end

    // Byte receiver; only listens while a request may still arrive (half duplex).
    always_comb begin
        rx_en     = state_q == IDLE || state_q == RX_ADDR || state_q == RX_CMD;
        start_ok  = 1'b0;
        byte_done = 1'b0;
        stop_err  = 1'b0;
        rph_d     = rph_q;
        rcnt_d    = rcnt_q + 1'b1;
        rbit_d    = rbit_q;
        shift_d   = shift_q;
        if (!rx_en) begin
            rph_d = R_IDLE;
        end else begin
            case (rph_q)
                R_IDLE: begin
                    rcnt_d = '0;
                    rph_d  = rx_prev_q && !rx_s2_q ? R_START : R_IDLE;
                end
                R_START: if (rcnt_q == RW'(HALF - 1)) begin
                    rcnt_d   = '0;
                    rbit_d   = '0;
                    start_ok = !rx_s2_q;
                    rph_d    = rx_s2_q ? R_IDLE : R_DATA;
                end
                R_DATA: if (rcnt_q == RW'(CLKS_PER_BIT - 1)) begin
                    rcnt_d  = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    rbit_d  = rbit_q + 1'b1;
                    rph_d   = rbit_q == 3'd7 ? R_STOP : R_DATA;
                end
                default: if (rcnt_q == RW'(CLKS_PER_BIT - 1)) begin
                    byte_done = rx_s2_q;
                    stop_err  = !rx_s2_q;
                    rph_d     = R_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        tbit_d    = tbit_q;
        match_d   = match_q;
        payload_d = payload_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: state_d = start_ok ? RX_ADDR : IDLE;
            RX_ADDR: begin
                if (stop_err) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (byte_done) begin
                    state_d = RX_CMD;
                    cnt_d   = '0;
                    match_d = shift_q == SENSOR_ADDR;
                end
            end
            RX_CMD: begin
                if (rph_q == R_DATA || rph_q == R_STOP) cnt_d = cnt_q;
                if (stop_err) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (byte_done) begin
                    state_d = CHECK;
                end else if ((rph_q == R_IDLE || rph_q == R_START) && !start_ok
                             && cnt_q == CW'(BYTE_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            CHECK: begin
                cnt_d     = '0;
                payload_d = shift_q == 8'h00 ? (sensor_valid ? sensor_data : 8'hFF) : {7'b0, sensor_valid};
                state_d   = !match_q ? IDLE : shift_q <= 8'h01 ? GAP : IDLE;
                err_d     = match_q && shift_q > 8'h01;
            end
            GAP: if (cnt_q == CW'(RESP_GAP - 2)) begin
                state_d = TX_ADDR;
                cnt_d   = '0;
                tbit_d  = '0;
            end
            TX_ADDR, TX_DATA, TX_SUM: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d  = '0;
                tbit_d = tbit_q == 4'd9 ? 4'd0 : tbit_q + 1'b1;
                if (tbit_q == 4'd9)
                    state_d = state_q == TX_ADDR ? TX_DATA : state_q == TX_DATA ? TX_SUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
        tbyte = state_d == TX_ADDR ? SENSOR_ADDR : state_d == TX_DATA ? payload_d : SENSOR_ADDR + payload_d;
        frame = {1'b1, tbyte, 1'b0};
        tx_d  = (state_d == TX_ADDR || state_d == TX_DATA || state_d == TX_SUM) ? frame[tbit_d] : 1'b1;
    end

    assign tx        = tx_q;
    assign busy      = state_q != IDLE;
    assign frame_err = err_q;
endmodule
